// File: rtl/cpu_pkg.sv
// Shared Pipeline_CPU definitions: instruction encodings and the fetch-stage state type.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'd0;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b010011;
    localparam logic [5:0] OP_BEQ    = 6'b011001;
    localparam logic [5:0] OP_LW     = 6'b011000;
    localparam logic [5:0] OP_SW     = 6'b101000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // An all-zero word in instruction memory marks the end of the program.
    function automatic logic is_end_word(input logic [31:0] instr);
        return instr == NOP_INSTR;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory addressing, IF/ID register and end-of-program drain/halt.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  DRAIN_CYCLES = 4,
    parameter int                  CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [PC_WIDTH-1:0]  redirect_pc_i,
    output logic [PC_WIDTH-1:0]  imem_addr_o,
    input  logic [31:0]          imem_instr_i,
    output logic [31:0]          ifid_instr_o,
    output logic [PC_WIDTH-1:0]  ifid_pc4_o,
    output logic                 ifid_valid_o,
    output logic                 halt_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    fetch_state_t         r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [31:0]          r_ifid_instr;
    logic [PC_WIDTH-1:0]  r_ifid_pc4;
    logic                 r_ifid_valid;
    logic                 r_halt;
    logic [DRAIN_W-1:0]   r_drain;

    logic [PC_WIDTH-1:0]  w_pc4;
    logic                 w_run;
    logic                 w_take_redirect;
    logic                 w_stall;
    logic                 w_fetch;

    assign w_pc4           = r_pc + PC_WIDTH'(4);
    assign w_run           = (r_state == ST_RUN);
    assign w_take_redirect = redirect_i && (w_run || (r_state == ST_DRAIN));
    // Stall only counts when it actually holds the pipe: a redirect overrides it.
    assign w_stall         = w_run && stall_i && !redirect_i;
    assign w_fetch         = w_run && !redirect_i && !stall_i && !is_end_word(imem_instr_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
            r_halt       <= 1'b0;
            r_drain      <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect_i) begin
                        r_pc         <= redirect_pc_i;
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                    end else if (!stall_i) begin
                        if (is_end_word(imem_instr_i)) begin
                            r_ifid_instr <= NOP_INSTR;
                            r_ifid_valid <= 1'b0;
                            r_drain      <= DRAIN_LOAD;
                            r_state      <= ST_DRAIN;
                        end else begin
                            r_ifid_instr <= imem_instr_i;
                            r_ifid_pc4   <= w_pc4;
                            r_ifid_valid <= 1'b1;
                            r_pc         <= w_pc4;
                        end
                    end
                end
                // IF/ID already holds a bubble; keep issuing it until ID..WB are empty.
                ST_DRAIN: begin
                    if (redirect_i) begin
                        r_pc    <= redirect_pc_i;
                        r_state <= ST_RUN;
                    end else if (r_drain == '0) begin
                        r_halt  <= 1'b1;
                        r_state <= ST_HALTED;
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr_o  = r_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_valid_o = r_ifid_valid;
    assign halt_o       = r_halt;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fetch_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_fetch),
        .cnt_o (fetch_cnt_o)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_stall),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_take_redirect),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural model compared every cycle plus directed literal checks.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int PCW  = 32;
    localparam int DRN  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic            redirect = 1'b0;
    logic [PCW-1:0]  redirect_pc = '0;
    logic [PCW-1:0]  imem_addr;
    logic [31:0]     imem_instr;
    logic [31:0]     ifid_instr;
    logic [PCW-1:0]  ifid_pc4;
    logic            ifid_valid;
    logic            halt;
    logic [CW-1:0]   fetch_cnt, stall_cnt, flush_cnt;

    logic [31:0] imem [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr[7:2]];

    fetch_stage #(
        .PC_WIDTH(PCW), .RESET_PC('0), .DRAIN_CYCLES(DRN), .CNT_WIDTH(CW)
    ) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .ifid_instr_o  (ifid_instr),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_valid_o  (ifid_valid),
        .halt_o        (halt),
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: program-level view of what IF must present.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;
    int          m_left;      // edges still to wait before halting; 0 = not draining
    int          m_fetch, m_stall, m_flush;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
            m_left = 0; m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (!m_halted) begin
            if (redirect) begin
                m_pc = redirect_pc; m_instr = 0; m_valid = 0;
                m_flush = sat_inc(m_flush); m_left = 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_halted = 1;
            end else if (stall) begin
                m_stall = sat_inc(m_stall);
            end else if (imem[m_pc[7:2]] == 32'd0) begin
                m_instr = 0; m_valid = 0; m_left = DRN;
            end else begin
                m_instr = imem[m_pc[7:2]]; m_pc4 = m_pc + 4; m_valid = 1;
                m_pc = m_pc + 4; m_fetch = sat_inc(m_fetch);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("m_addr",  imem_addr,  m_pc);
            check("m_valid", ifid_valid, m_valid);
            check("m_instr", ifid_instr, m_instr);
            if (m_valid) check("m_pc4", ifid_pc4, m_pc4);
            check("m_halt",  halt,       m_halted);
            check("m_fcnt",  fetch_cnt,  m_fetch);
            check("m_scnt",  stall_cnt,  m_stall);
            check("m_xcnt",  flush_cnt,  m_flush);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!halt && n < max) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", halt, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    logic [31:0] i_addi, i_add, i_sw, i_lw, i_beq;

    initial begin
        i_addi = {OP_ADDI, 5'd0, 5'd1, 16'd5};
        i_add  = {OP_R_TYPE, 5'd1, 5'd1, 5'd2, 5'd0, FUNCT_ADD};
        i_sw   = {OP_SW, 5'd0, 5'd2, 16'd0};
        i_lw   = {OP_LW, 5'd0, 5'd3, 16'd4};
        i_beq  = {OP_BEQ, 5'd1, 5'd2, 16'd0};
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        imem[0] = i_addi; imem[1] = i_add; imem[2] = i_sw; imem[3] = 32'd0;
        imem[8] = i_lw;   imem[9] = i_beq; imem[10] = 32'd0;

        // Straight program, end-of-program drain and halt
        do_reset();
        check("rst_addr", imem_addr, 0);
        check("rst_valid", ifid_valid, 0);
        check("rst_fcnt", fetch_cnt, 0);
        step(1);
        check("p1_addr", imem_addr, 4);
        check("p1_pc4", ifid_pc4, 4);
        check("p1_valid", ifid_valid, 1);
        check("p1_instr", ifid_instr, i_addi);
        step(1);
        check("p2_pc4", ifid_pc4, 8);
        step(1);
        check("p3_addr", imem_addr, 12);
        check("p3_pc4", ifid_pc4, 12);
        check("p3_instr", ifid_instr, i_sw);
        check("p3_fcnt", fetch_cnt, 3);
        step(1);
        check("drain_valid", ifid_valid, 0);
        check("drain_addr", imem_addr, 12);
        step(3);
        check("drain3_halt", halt, 0);
        step(1);
        check("drain4_halt", halt, 1);
        step(3);
        check("halted_addr", imem_addr, 12);
        check("halted_sticky", halt, 1);

        // Load-use stall at PC=8
        do_reset();
        step(2);
        check("s0_addr", imem_addr, 8);
        stall = 1'b1;
        step(1);
        check("s1_addr", imem_addr, 8);
        check("s1_pc4", ifid_pc4, 8);
        check("s1_scnt", stall_cnt, 1);
        step(1);
        check("s2_addr", imem_addr, 8);
        check("s2_instr", ifid_instr, i_add);
        check("s2_scnt", stall_cnt, 2);
        stall = 1'b0;
        step(1);
        check("s3_addr", imem_addr, 12);
        check("s3_pc4", ifid_pc4, 12);
        check("s3_fcnt", fetch_cnt, 3);
        wait_halt(20);

        // Redirect with stall, then redirect out of DRAIN
        do_reset();
        step(1);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h20;
        step(1);
        redirect = 1'b0; stall = 1'b0;
        check("r_addr", imem_addr, 32'h20);
        check("r_valid", ifid_valid, 0);
        check("r_xcnt", flush_cnt, 1);
        check("r_scnt", stall_cnt, 0);
        step(1);
        check("r_pc4", ifid_pc4, 32'h24);
        check("r_instr", ifid_instr, i_lw);
        step(2);
        check("rd_addr", imem_addr, 32'h28);
        check("rd_valid", ifid_valid, 0);
        step(1);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h04;
        step(1);
        redirect = 1'b0; stall = 1'b0;
        check("rd_redir_addr", imem_addr, 4);
        check("rd_halt", halt, 0);
        check("rd_xcnt", flush_cnt, 2);
        check("rd_scnt", stall_cnt, 0);
        step(1);
        check("rd_refetch_pc4", ifid_pc4, 8);
        check("rd_refetch_valid", ifid_valid, 1);
        check("rd_fcnt", fetch_cnt, 4);
        wait_halt(20);
        check("rd_final_addr", imem_addr, 12);

        // Asynchronous reset mid-run and while halted
        do_reset();
        step(2);
        check("a_addr", imem_addr, 8);
        #2 rst_n = 1'b0;
        #1;
        check("a_rst_addr", imem_addr, 0);
        check("a_rst_valid", ifid_valid, 0);
        check("a_rst_instr", ifid_instr, 0);
        check("a_rst_pc4", ifid_pc4, 0);
        check("a_rst_fcnt", fetch_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("a_refetch_addr", imem_addr, 4);
        wait_halt(20);
        #2 rst_n = 1'b0;
        #1;
        check("ah_rst_halt", halt, 0);
        check("ah_rst_addr", imem_addr, 0);
        check("ah_rst_xcnt", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("ah_refetch_addr", imem_addr, 4);
        check("ah_refetch_pc4", ifid_pc4, 4);
        check("ah_refetch_valid", ifid_valid, 1);

        // Counter saturation
        do_reset();
        step(1);
        stall = 1'b1;
        step(20);
        check("sat_scnt", stall_cnt, CMAX);
        check("sat_addr", imem_addr, 4);
        stall = 1'b0;
        step(1);
        check("sat_resume_addr", imem_addr, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
